// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Parametrised VGA raster timing generator with pixel clock-enable,
//            programmable sync polarity and pipeline-aligned sync/blank/de.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CW        = 10,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int PIXEL_DLY = 2,
    parameter int FCW       = 8
) (
    input  logic           clk_25,
    input  logic           rst_n,
    input  logic           ce,
    output logic [CW-1:0]  hs,
    output logic [CW-1:0]  vs,
    output logic           vga_hsync,
    output logic           vga_vsync,
    output logic           sync_b,
    output logic           sync_blank,
    output logic           de,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_cnt
);

    localparam int c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_hs_beg   = H_ACTIVE + H_FP;
    localparam int c_hs_end   = c_hs_beg + H_SYNC;
    localparam int c_vs_beg   = V_ACTIVE + V_FP;
    localparam int c_vs_end   = c_vs_beg + V_SYNC;
    localparam logic [CW-1:0] c_h_last = CW'(c_h_total - 1);
    localparam logic [CW-1:0] c_v_last = CW'(c_v_total - 1);

    generate
        if (c_h_total > (1 << CW)) begin : g_chk_h_total
            $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
        end
        if (c_v_total > (1 << CW)) begin : g_chk_v_total
            $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
        end
        if (PIXEL_DLY < 1 || PIXEL_DLY > 8) begin : g_chk_dly
            $error("vga_timing_gen: PIXEL_DLY must be within 1..8");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Raster counters, strobes and frame counter
    // ------------------------------------------------------------------
    logic [CW-1:0]  hs_q, hs_d;
    logic [CW-1:0]  vs_q, vs_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           ls_q, ls_d;
    logic           fs_q, fs_d;

    always_comb begin
        hs_d   = hs_q;
        vs_d   = vs_q;
        fcnt_d = fcnt_q;
        ls_d   = 1'b0;
        fs_d   = 1'b0;
        if (ce) begin
            ls_d = (hs_q == '0);
            fs_d = (hs_q == '0) && (vs_q == '0);
            if (hs_q == c_h_last) begin
                hs_d = '0;
                if (vs_q == c_v_last) begin
                    vs_d   = '0;
                    fcnt_d = fcnt_q + FCW'(1);
                end else begin
                    vs_d = vs_q + CW'(1);
                end
            end else begin
                hs_d = hs_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            hs_q   <= '0;
            vs_q   <= '0;
            fcnt_q <= '0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            fcnt_q <= fcnt_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
        end
    end

    // ------------------------------------------------------------------
    // Window decode of the current raster position
    // ------------------------------------------------------------------
    logic [31:0] w_h32;
    logic [31:0] w_v32;
    logic        w_h_act;
    logic        w_v_act;
    logic        w_hsync_act;
    logic        w_vsync_act;
    logic [2:0]  w_dec;
    logic [2:0]  w_tap;

    // Widen before comparing so window ends equal to 2^CW stay representable.
    assign w_h32       = 32'(hs_q);
    assign w_v32       = 32'(vs_q);
    assign w_h_act     = (w_h32 < 32'(H_ACTIVE));
    assign w_v_act     = (w_v32 < 32'(V_ACTIVE));
    assign w_hsync_act = (w_h32 >= 32'(c_hs_beg)) && (w_h32 < 32'(c_hs_end));
    assign w_vsync_act = (w_v32 >= 32'(c_vs_beg)) && (w_v32 < 32'(c_vs_end));
    assign w_dec       = {w_hsync_act, w_vsync_act, w_h_act & w_v_act};

    // ------------------------------------------------------------------
    // Alignment pipeline: PIXEL_DLY-1 stages here, the last is the output
    // register so that every pin comes straight from a flop.
    // ------------------------------------------------------------------
    generate
        if (PIXEL_DLY == 1) begin : g_tap_direct
            assign w_tap = w_dec;
        end else begin : g_tap_pipe
            logic [2:0] pipe_q [PIXEL_DLY-1];

            always_ff @(posedge clk_25 or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIXEL_DLY - 1; i++) begin
                        pipe_q[i] <= 3'b000;
                    end
                end else if (ce) begin
                    pipe_q[0] <= w_dec;
                    for (int i = 1; i < PIXEL_DLY - 1; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign w_tap = pipe_q[PIXEL_DLY-2];
        end
    endgenerate

    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic syncb_q, syncb_d;
    logic blank_q, blank_d;
    logic de_q,    de_d;

    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        syncb_d = syncb_q;
        blank_d = blank_q;
        de_d    = de_q;
        if (ce) begin
            hsync_d = w_tap[2] ? HS_POL : ~HS_POL;
            vsync_d = w_tap[1] ? VS_POL : ~VS_POL;
            syncb_d = ~(w_tap[2] | w_tap[1]);
            blank_d = ~w_tap[0];
            de_d    = w_tap[0];
        end
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            syncb_q <= 1'b1;
            blank_q <= 1'b1;
            de_q    <= 1'b0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            syncb_q <= syncb_d;
            blank_q <= blank_d;
            de_q    <= de_d;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign sync_b      = syncb_q;
    assign sync_blank  = blank_q;
    assign de          = de_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_cnt   = fcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Self-checking bench for vga_timing_gen, three parameter sets
//            compared against an arithmetic raster model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ce    = 1'b0;

    always #5 clk = ~clk;

    // A: default 640x480, B: tiny raster, positive syncs, delay 5
    // C: tiny raster, delay 1, 3-bit frame counter
    logic [9:0] hsA, vsA;
    logic       hyA, vyA, sbA, blA, deA, lsA, fsA;
    logic [7:0] fcA;
    logic [3:0] hsB, vsB;
    logic       hyB, vyB, sbB, blB, deB, lsB, fsB;
    logic [7:0] fcB;
    logic [3:0] hsC, vsC;
    logic       hyC, vyC, sbC, blC, deC, lsC, fsC;
    logic [2:0] fcC;

    vga_timing_gen u_dut_a (
        .clk_25(clk), .rst_n(rst_n), .ce(ce), .hs(hsA), .vs(vsA),
        .vga_hsync(hyA), .vga_vsync(vyA), .sync_b(sbA), .sync_blank(blA),
        .de(deA), .line_start(lsA), .frame_start(fsA), .frame_cnt(fcA)
    );

    vga_timing_gen #(
        .CW(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIXEL_DLY(5), .FCW(8)
    ) u_dut_b (
        .clk_25(clk), .rst_n(rst_n), .ce(ce), .hs(hsB), .vs(vsB),
        .vga_hsync(hyB), .vga_vsync(vyB), .sync_b(sbB), .sync_blank(blB),
        .de(deB), .line_start(lsB), .frame_start(fsB), .frame_cnt(fcB)
    );

    vga_timing_gen #(
        .CW(4), .H_ACTIVE(5), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIXEL_DLY(1), .FCW(3)
    ) u_dut_c (
        .clk_25(clk), .rst_n(rst_n), .ce(ce), .hs(hsC), .vs(vsC),
        .vga_hsync(hyC), .vga_vsync(vyC), .sync_b(sbC), .sync_blank(blC),
        .de(deC), .line_start(lsC), .frame_start(fsC), .frame_cnt(fcC)
    );

    typedef struct packed {
        logic [9:0] hs;
        logic [9:0] vs;
        logic       hsync;
        logic       vsync;
        logic       sync_b;
        logic       blank;
        logic       de;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } outs_t;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ce     = 0;      // ce-enabled edges since reset release
    bit last_ce  = 1'b0;   // previous edge was an enabled edge out of reset

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h (t=%0t, n=%0d)", tag, obs, exp, $time, n_ce);
        end
    endtask

    // Expected outputs after n enabled edges: the raster position is simply n
    // modulo the frame size, and the sync/blank view lags it by dly edges.
    function automatic outs_t model(input int n, input bit lc,
                                    input int ha, input int hf, input int hw, input int hb,
                                    input int va, input int vf, input int vw, input int vb,
                                    input bit hp, input bit vp, input int dly, input int fcw);
        outs_t o;
        int ht, vt, t, p, q, h, v;
        bit hsa, vsa, act;
        ht   = ha + hf + hw + hb;
        vt   = va + vf + vw + vb;
        t    = ht * vt;
        p    = n % t;
        o.hs = 10'(p % ht);
        o.vs = 10'(p / ht);
        o.fc = 8'((n / t) % (1 << fcw));
        o.ls = lc && ((n - 1) % ht == 0);
        o.fs = lc && ((n - 1) % t == 0);
        hsa  = 1'b0;
        vsa  = 1'b0;
        act  = 1'b0;
        if (n >= dly) begin
            q   = (n - dly) % t;
            h   = q % ht;
            v   = q / ht;
            hsa = (h >= ha + hf) && (h < ha + hf + hw);
            vsa = (v >= va + vf) && (v < va + vf + vw);
            act = (h < ha) && (v < va);
        end
        o.hsync  = hsa ? hp : !hp;
        o.vsync  = vsa ? vp : !vp;
        o.sync_b = !(hsa || vsa);
        o.blank  = !act;
        o.de     = act;
        return o;
    endfunction

    task automatic compare_all();
        outs_t eA, eB, eC, oA, oB, oC;
        eA = model(n_ce, last_ce, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2, 8);
        eB = model(n_ce, last_ce, 8, 2, 3, 2, 4, 1, 1, 1, 1'b1, 1'b1, 5, 8);
        eC = model(n_ce, last_ce, 5, 1, 2, 1, 3, 1, 1, 2, 1'b0, 1'b0, 1, 3);
        oA = '{hs: hsA, vs: vsA, hsync: hyA, vsync: vyA, sync_b: sbA,
               blank: blA, de: deA, ls: lsA, fs: fsA, fc: fcA};
        oB = '{hs: 10'(hsB), vs: 10'(vsB), hsync: hyB, vsync: vyB, sync_b: sbB,
               blank: blB, de: deB, ls: lsB, fs: fsB, fc: fcB};
        oC = '{hs: 10'(hsC), vs: 10'(vsC), hsync: hyC, vsync: vyC, sync_b: sbC,
               blank: blC, de: deC, ls: lsC, fs: fsC, fc: 8'(fcC)};
        check_eq("A outputs", {29'b0, oA}, {29'b0, eA});
        check_eq("B outputs", {29'b0, oB}, {29'b0, eB});
        check_eq("C outputs", {29'b0, oC}, {29'b0, eC});
        if (last_ce && n_ce == 1) begin
            check_eq("A first frame_start", fsA, 1);
            check_eq("A first line_start", lsA, 1);
            check_eq("A hs after first edge", hsA, 1);
        end
        if (last_ce && n_ce == 5) check_eq("B de rises after 5 edges", deB, 1);
        if (last_ce && n_ce == 3 * 105) check_eq("B frame_cnt 3 frames", fcB, 3);
        if (last_ce && n_ce == 255 * 105) check_eq("B frame_cnt 255 frames", fcB, 255);
        if (last_ce && n_ce == 256 * 105) check_eq("B frame_cnt wrap 256", fcB, 0);
        if (last_ce && n_ce == 8 * 63) check_eq("C frame_cnt wrap 8", fcC, 0);
    endtask

    // Caller is positioned at a falling edge; returns at a falling edge.
    // mode 0: ce held high, 1: ce toggles 1,0,1,0, 2: random ce.
    task automatic run_cycles(input int cnt, input int mode);
        for (int i = 0; i < cnt; i++) begin
            case (mode)
                0:       ce = 1'b1;
                1:       ce = (i % 2 == 0);
                default: ce = ($urandom_range(3) != 0);
            endcase
            @(posedge clk);
            if (ce) n_ce++;
            last_ce = ce;
            #1;
            compare_all();
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ce    = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst A hs", hsA, 0);
        check_eq("rst A vs", vsA, 0);
        check_eq("rst A vga_hsync", hyA, 1);
        check_eq("rst A vga_vsync", vyA, 1);
        check_eq("rst A sync_b", sbA, 1);
        check_eq("rst A sync_blank", blA, 1);
        check_eq("rst A de", deA, 0);
        check_eq("rst A frame_cnt", fcA, 0);
        check_eq("rst A frame_start", fsA, 0);
        check_eq("rst B vga_hsync idle", hyB, 0);
        check_eq("rst B vga_vsync idle", vyB, 0);
        compare_all();

        @(negedge clk);
        rst_n = 1'b1;
        run_cycles(1700, 0);
        run_cycles(1000, 1);
        run_cycles(3000, 2);

        // asynchronous reset in mid-cycle, away from any clock edge
        #2 rst_n = 1'b0;
        #1;
        n_ce    = 0;
        last_ce = 1'b0;
        check_eq("async rst A hs", hsA, 0);
        check_eq("async rst A de", deA, 0);
        check_eq("async rst A frame_cnt", fcA, 0);
        check_eq("async rst B sync_b", sbB, 1);
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        run_cycles(400, 2);
        // restart once more so the long run counts frames from zero
        #2 rst_n = 1'b0;
        #1;
        n_ce    = 0;
        last_ce = 1'b0;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        run_cycles(27000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: the next generation of the team's fixed 640x480 controller. It adds configurable porch, sync and active widths, sync polarity, a pixel clock-enable for running from a faster system clock, and a programmable output delay that aligns sync and blank with a PIXEL_DLY-stage pixel-fetch pipeline. It also generates frame/line strobes and a frame counter. It sits between the clock/reset logic and the VGA DAC/pixel pipeline; the raw counters feed framebuffer address generation.

## Interface
- CW, 10: width of hs/vs counters; must hold H_TOTAL-1 and V_TOTAL-1
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch
- H_SYNC, 96: horizontal sync width
- H_BP, 48: horizontal back porch (H_TOTAL = sum = 800)
- V_ACTIVE, 480: visible lines
- V_FP, 10: vertical front porch
- V_SYNC, 2: vertical sync width
- V_BP, 33: vertical back porch (V_TOTAL = 525)
- HS_POL, 0: hsync active level (0 = active low)
- VS_POL, 0: vsync active level
- PIXEL_DLY, 2: ce-cycles of delay on sync/blank/de outputs; range 1..8
- FCW, 8: frame counter width

Ports:
- clk_25  in  1  pixel/system clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  pixel clock enable; all state advances only when ce=1
- hs  out  CW  horizontal counter, undelayed
- vs  out  CW  vertical counter, undelayed
- vga_hsync  out  1  delayed horizontal sync at HS_POL
- vga_vsync  out  1  delayed vertical sync at VS_POL
- sync_b  out  1  composite sync, delayed; active low = ~(hsync_act | vsync_act)
- sync_blank  out  1  delayed blank, 1 outside active area
- de  out  1  delayed data enable, ~sync_blank
- line_start  out  1  one-clk pulse, undelayed, when ce=1 and hs==0
- frame_start  out  1  one-clk pulse, undelayed, when ce=1 and hs==0, vs==0
- frame_cnt  out  FCW  frames completed, wraps

## Operation
- On ce=1: hs increments; at hs==H_TOTAL-1 it wraps to 0 and vs increments; at vs==V_TOTAL-1 with hs wrap, vs wraps to 0 and frame_cnt increments (modulo 2^FCW).
- ce=0: counters, delay line and frame_cnt hold; line_start/frame_start are 0.
- Decode from current (hs,vs): h_act = hs<H_ACTIVE; hsync_act = H_ACTIVE+H_FP <= hs < H_ACTIVE+H_FP+H_SYNC; v_act, vsync_act analogously with V_*.
- Decoded bits (hsync_act, vsync_act, h_act&v_act) enter a PIXEL_DLY-deep shift register, shifted only on ce=1. Outputs are driven from the last stage: vga_hsync = hsync_act XNOR HS_POL... i.e. equal to HS_POL when active, ~HS_POL otherwise; same for vsync.
- All outputs registered; no combinational path from ce to syncs.
- Elaboration-time check: error if H_TOTAL>2^CW, V_TOTAL>2^CW, or PIXEL_DLY outside 1..8.

## Timing
- Reset (async assert, rst_n=0): hs=0, vs=0, frame_cnt=0, line_start=0, frame_start=0, all delay stages cleared to inactive: vga_hsync=~HS_POL, vga_vsync=~VS_POL, sync_b=1, sync_blank=1, de=0.
- Reset release: first ce=1 edge raises frame_start and line_start for one clk (counters at 0,0), then hs becomes 1.
- Reset mid-frame: everything returns immediately to reset values; no partial-frame frame_cnt increment.
- Latency: decoded state of counter value (h,v) appears on sync/blank/de exactly PIXEL_DLY ce-enabled edges after hs,vs showed (h,v).
- Wrap: frame_cnt increments on the same edge vs,hs go to 0,0; frame_start is asserted in the following ce-cycle while (0,0) is presented.
- Line period H_TOTAL ce-cycles; frame period H_TOTAL*V_TOTAL ce-cycles.

## Test plan
- Reset: hold rst_n=0 with ce=1 -> hs=vs=0, vga_hsync=1, vga_vsync=1, sync_blank=1, de=0, frame_cnt=0.
- Default params, ce=1 continuously, PIXEL_DLY=2 -> vga_hsync low for 96 clks per line, starting 2 clks after hs==656; de high 640 clks per line on lines 0..479; vga_vsync low for 2 lines (vs 490,491) delayed 2 clks; frame_start spacing 420000 clks.
- ce toggling 1,0,1,0 -> all periods double (frame_start every 840000 clks), outputs never change on ce=0 cycles, pulses 1 clk wide.
- HS_POL=1, VS_POL=1 -> syncs idle low, high during sync windows; sync_b unchanged in behaviour (low during either sync).
- PIXEL_DLY=5, small mode H=8/2/3/2, V=4/1/1/1 -> de rises exactly 5 ce-edges after hs==0 on vs 0..3; hs wraps at 14, vs at 6; frame_cnt after 3 frames = 3, wraps at 256 frames with FCW=8.
- Assert rst_n=0 at hs=300, vs=200 for 1 clk -> outputs snap to reset values asynchronously; frame_start first pulse on first ce after release, frame_cnt=0.
